// File: rtl/ace_line_responder.sv
// Single-line ACE subordinate: serves 4-beat line reads from, and accepts 4-beat
// line writes into, a one-line store so the active path can run closed-loop.
module ace_line_responder #(
  parameter int unsigned C_ACE_DATA_WIDTH = 128,
  parameter int unsigned C_ACE_ADDR_WIDTH = 44,
  parameter int unsigned RESP_STATE_SIZE  = 3
) (
  input  logic                          ace_aclk,
  input  logic                          ace_areset,
  input  logic                          i_arvalid,
  output logic                          o_arready,
  input  logic [C_ACE_ADDR_WIDTH-1:0]   i_araddr,
  input  logic [7:0]                    i_arlen,
  output logic                          o_rvalid,
  input  logic                          i_rready,
  output logic [C_ACE_DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]                    o_rresp,
  output logic                          o_rlast,
  input  logic                          i_rack,
  input  logic                          i_awvalid,
  output logic                          o_awready,
  input  logic [C_ACE_ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [7:0]                    i_awlen,
  input  logic                          i_wvalid,
  output logic                          o_wready,
  input  logic [C_ACE_DATA_WIDTH-1:0]   i_wdata,
  input  logic                          i_wlast,
  output logic                          o_bvalid,
  input  logic                          i_bready,
  output logic [1:0]                    o_bresp,
  input  logic                          i_wack,
  input  logic                          i_line_load,
  input  logic [C_ACE_ADDR_WIDTH-1:0]   i_line_addr,
  input  logic [4*C_ACE_DATA_WIDTH-1:0] i_cache_line,
  output logic [4*C_ACE_DATA_WIDTH-1:0] o_cache_line,
  output logic                          o_line_valid,
  output logic                          o_busy,
  output logic [RESP_STATE_SIZE-1:0]    o_fsm_state
);

  localparam int unsigned TAG_W    = C_ACE_ADDR_WIDTH - 6;
  localparam logic [7:0]  FULL_LEN = 8'd3;
  localparam logic [7:0]  BEAT_MAX = 8'hFF;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    R_DATA = 3'd1,
    R_ACK  = 3'd2,
    W_DATA = 3'd3,
    B_RESP = 3'd4,
    W_ACK  = 3'd5
  } state_t;

  state_t state, next_state;

  logic [3:0][C_ACE_DATA_WIDTH-1:0] buffer;
  logic [TAG_W-1:0] tag;
  logic             valid;
  logic [7:0]       len;
  logic [7:0]       beat;
  logic             hit;
  logic             err;
  logic             ar_fire, aw_fire, r_fire, w_fire;

  // Line offset bits never select anything: the store holds exactly one line.
  logic unused_ok;
  assign unused_ok = ^{i_araddr[5:0], i_awaddr[5:0], i_line_addr[5:0]};

  assign o_cache_line = buffer;
  assign o_line_valid = valid;
  assign o_busy       = (state != IDLE);
  assign o_fsm_state  = RESP_STATE_SIZE'(state);

  always_ff @(posedge ace_aclk) begin
    if (ace_areset) state <= IDLE;
    else            state <= next_state;
  end

  // Next state, handshake outputs and read-beat selection.
  always_comb begin
    next_state = state;
    o_arready  = 1'b0;
    o_awready  = 1'b0;
    o_rvalid   = 1'b0;
    o_rdata    = '0;
    o_rresp    = RESP_OKAY;
    o_rlast    = 1'b0;
    o_wready   = 1'b0;
    o_bvalid   = 1'b0;
    o_bresp    = RESP_OKAY;
    ar_fire    = 1'b0;
    aw_fire    = 1'b0;
    r_fire     = 1'b0;
    w_fire     = 1'b0;
    case (state)
      IDLE: begin
        o_arready = !ace_areset && !i_line_load;
        o_awready = !ace_areset && !i_line_load && !i_arvalid;
        ar_fire   = i_arvalid && o_arready;
        aw_fire   = i_awvalid && o_awready;
        if (ar_fire)      next_state = R_DATA;
        else if (aw_fire) next_state = W_DATA;
      end
      R_DATA: begin
        o_rvalid = 1'b1;
        o_rdata  = (hit && len == FULL_LEN) ? buffer[beat[1:0]] : '0;
        o_rresp  = (len != FULL_LEN) ? RESP_SLVERR : RESP_OKAY;
        o_rlast  = (beat == len);
        r_fire   = i_rready;
        if (r_fire && o_rlast) next_state = R_ACK;
      end
      R_ACK: begin
        if (i_rack) next_state = IDLE;
      end
      W_DATA: begin
        o_wready = 1'b1;
        w_fire   = i_wvalid;
        if (w_fire && i_wlast) next_state = B_RESP;
      end
      B_RESP: begin
        o_bvalid = 1'b1;
        o_bresp  = err ? RESP_SLVERR : RESP_OKAY;
        if (i_bready) next_state = W_ACK;
      end
      W_ACK: begin
        if (i_wack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Line store, tag and per-transaction bookkeeping.
  always_ff @(posedge ace_aclk) begin
    if (ace_areset) begin
      buffer <= '0;
      tag    <= '0;
      valid  <= 1'b0;
      len    <= '0;
      beat   <= '0;
      hit    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_line_load) begin
            buffer <= i_cache_line;
            tag    <= i_line_addr[C_ACE_ADDR_WIDTH-1:6];
            valid  <= 1'b1;
          end else if (ar_fire) begin
            len  <= i_arlen;
            hit  <= valid && (tag == i_araddr[C_ACE_ADDR_WIDTH-1:6]);
            beat <= '0;
          end else if (aw_fire) begin
            len  <= i_awlen;
            err  <= (i_awlen != FULL_LEN);
            beat <= '0;
            if (i_awlen == FULL_LEN) begin
              tag   <= i_awaddr[C_ACE_ADDR_WIDTH-1:6];
              valid <= 1'b1;
            end
          end
        end
        R_DATA: begin
          if (r_fire) beat <= beat + 8'd1;
        end
        W_DATA: begin
          if (w_fire) begin
            if (!err) buffer[beat[1:0]] <= i_wdata;
            if (beat != BEAT_MAX) beat <= beat + 8'd1;
            err <= err || (beat == BEAT_MAX) || (i_wlast && beat != len);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ace_line_responder.sv
// Directed + randomized bench for ace_line_responder against a line-store model.
module tb_ace_line_responder;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_RDATA = 3'd1, ST_RACK = 3'd2,
                         ST_WDATA = 3'd3, ST_BRESP = 3'd4, ST_WACK = 3'd5;

  logic         ace_aclk, ace_areset;
  logic         i_arvalid, o_arready;
  logic [43:0]  i_araddr;
  logic [7:0]   i_arlen;
  logic         o_rvalid, i_rready;
  logic [127:0] o_rdata;
  logic [1:0]   o_rresp;
  logic         o_rlast, i_rack;
  logic         i_awvalid, o_awready;
  logic [43:0]  i_awaddr;
  logic [7:0]   i_awlen;
  logic         i_wvalid, o_wready;
  logic [127:0] i_wdata;
  logic         i_wlast, o_bvalid, i_bready;
  logic [1:0]   o_bresp;
  logic         i_wack, i_line_load;
  logic [43:0]  i_line_addr;
  logic [511:0] i_cache_line, o_cache_line;
  logic         o_line_valid, o_busy;
  logic [2:0]   o_fsm_state;

  int total = 0;
  int bad   = 0;

  // Reference model: one line of four beats plus its tag and valid bit.
  logic [127:0] m_line [4];
  logic [37:0]  m_tag;
  logic         m_valid;

  ace_line_responder dut (
    .ace_aclk(ace_aclk), .ace_areset(ace_areset),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr), .i_arlen(i_arlen),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .o_rlast(o_rlast), .i_rack(i_rack),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr), .i_awlen(i_awlen),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wlast(i_wlast),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp), .i_wack(i_wack),
    .i_line_load(i_line_load), .i_line_addr(i_line_addr), .i_cache_line(i_cache_line),
    .o_cache_line(o_cache_line), .o_line_valid(o_line_valid), .o_busy(o_busy),
    .o_fsm_state(o_fsm_state)
  );

  initial ace_aclk = 1'b0;
  always #5 ace_aclk = ~ace_aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [511:0] model_line();
    return {m_line[3], m_line[2], m_line[1], m_line[0]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cycle();
    @(posedge ace_aclk);
    @(negedge ace_aclk);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic preload(input logic [43:0] a, input logic [511:0] ln, input bit contend);
    i_line_load = 1'b1; i_line_addr = a; i_cache_line = ln;
    if (contend) begin i_arvalid = 1'b1; i_awvalid = 1'b1; i_awlen = 8'd3; end
    #1 check("load_arready", 512'(o_arready), 512'(0));
    check("load_awready", 512'(o_awready), 512'(0));
    cycle();
    i_line_load = 1'b0; i_arvalid = 1'b0; i_awvalid = 1'b0;
    for (int i = 0; i < 4; i++) m_line[i] = ln[i*128 +: 128];
    m_tag = a[43:6]; m_valid = 1'b1;
    #1 check("load_state", 512'(o_fsm_state), 512'(ST_IDLE));
    check("load_line", o_cache_line, model_line());
    check("load_valid", 512'(o_line_valid), 512'(1));
  endtask

  task automatic read_txn(input logic [43:0] a, input logic [7:0] len,
                          input bit rnd_ready, input bit early_rack);
    bit hit; int b; int guard;
    logic [127:0] exp_d;
    hit = m_valid && (m_tag == a[43:6]);
    i_arvalid = 1'b1; i_araddr = a; i_arlen = len;
    #1 check("ar_ready", 512'(o_arready), 512'(1));
    cycle();
    i_arvalid = 1'b0;
    b = 0; guard = 0;
    while (b <= int'(len) && guard < 200) begin
      i_rready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      i_rack   = early_rack && (b == int'(len));
      exp_d = (hit && len == 8'd3) ? m_line[b % 4] : 128'd0;
      #1 check("r_valid", 512'(o_rvalid), 512'(1));
      check("r_data", 512'(o_rdata), 512'(exp_d));
      check("r_last", 512'(o_rlast), 512'(b == int'(len)));
      check("r_resp", 512'(o_rresp), 512'((len != 8'd3) ? 2'b10 : 2'b00));
      @(posedge ace_aclk);
      if (i_rready) b++;
      @(negedge ace_aclk);
      i_rack = 1'b0;
      guard++;
    end
    check("r_beats_bounded", 512'(guard < 200), 512'(1));
    i_rready = 1'b0;
    #1 check("r_ack_state", 512'(o_fsm_state), 512'(ST_RACK));
    check("r_ack_rvalid", 512'(o_rvalid), 512'(0));
    repeat ($urandom_range(0, 2)) begin
      cycle();
      #1 check("r_ack_hold", 512'(o_fsm_state), 512'(ST_RACK));
    end
    i_rack = 1'b1;
    cycle();
    i_rack = 1'b0;
    #1 check("r_done_state", 512'(o_fsm_state), 512'(ST_IDLE));
    check("r_done_busy", 512'(o_busy), 512'(0));
  endtask

  task automatic write_txn(input logic [43:0] a, input logic [7:0] len, input int nbeats,
                           input bit gaps, input bit early_wack);
    bit merr;
    logic [127:0] d;
    i_awvalid = 1'b1; i_awaddr = a; i_awlen = len;
    #1 check("aw_ready", 512'(o_awready), 512'(1));
    cycle();
    i_awvalid = 1'b0;
    merr = (len != 8'd3);
    if (!merr) begin m_tag = a[43:6]; m_valid = 1'b1; end
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          i_wvalid = 1'b0;
          i_line_load = 1'($urandom_range(0, 1));
          i_line_addr = 44'h7000; i_cache_line = {4{rand128()}};
          #1 check("w_gap_state", 512'(o_fsm_state), 512'(ST_WDATA));
          check("w_gap_bvalid", 512'(o_bvalid), 512'(0));
          cycle();
          i_line_load = 1'b0;
        end
      end
      d = rand128();
      i_wvalid = 1'b1; i_wdata = d; i_wlast = (i == nbeats - 1);
      #1 check("w_ready", 512'(o_wready), 512'(1));
      cycle();
      if (!merr) m_line[i % 4] = d;
      if (i == nbeats - 1 && i != int'(len)) merr = 1'b1;
    end
    i_wvalid = 1'b0; i_wlast = 1'b0;
    #1 check("b_valid", 512'(o_bvalid), 512'(1));
    check("b_resp", 512'(o_bresp), 512'(merr ? 2'b10 : 2'b00));
    check("w_line", o_cache_line, model_line());
    check("w_line_valid", 512'(o_line_valid), 512'(m_valid));
    repeat ($urandom_range(0, 2)) begin
      cycle();
      #1 check("b_hold", 512'(o_bvalid), 512'(1));
    end
    i_bready = 1'b1; i_wack = early_wack;
    cycle();
    i_bready = 1'b0; i_wack = 1'b0;
    #1 check("w_ack_state", 512'(o_fsm_state), 512'(ST_WACK));
    check("w_ack_bvalid", 512'(o_bvalid), 512'(0));
    repeat ($urandom_range(0, 2)) begin
      cycle();
      #1 check("w_ack_hold", 512'(o_fsm_state), 512'(ST_WACK));
    end
    i_wack = 1'b1;
    cycle();
    i_wack = 1'b0;
    #1 check("w_done_state", 512'(o_fsm_state), 512'(ST_IDLE));
  endtask

  initial begin
    logic [43:0]  a;
    logic [7:0]   ln8;
    logic [511:0] pl;
    int kind; int nb;
    logic [43:0] bases [3];
    bases[0] = 44'h1000; bases[1] = 44'h2000; bases[2] = 44'h3000;

    i_arvalid = 0; i_araddr = 0; i_arlen = 0; i_rready = 0; i_rack = 0;
    i_awvalid = 0; i_awaddr = 0; i_awlen = 0; i_wvalid = 0; i_wdata = 0; i_wlast = 0;
    i_bready = 0; i_wack = 0; i_line_load = 0; i_line_addr = 0; i_cache_line = 0;
    for (int i = 0; i < 4; i++) m_line[i] = '0;
    m_tag = '0; m_valid = 1'b0;
    ace_areset = 1'b1;
    repeat (2) @(posedge ace_aclk);
    @(negedge ace_aclk);

    #1 check("rst_state", 512'(o_fsm_state), 512'(ST_IDLE));
    check("rst_arready", 512'(o_arready), 512'(0));
    check("rst_awready", 512'(o_awready), 512'(0));
    check("rst_rvalid", 512'(o_rvalid), 512'(0));
    check("rst_wready", 512'(o_wready), 512'(0));
    check("rst_bvalid", 512'(o_bvalid), 512'(0));
    check("rst_rdata", 512'(o_rdata), 512'(0));
    check("rst_rlast", 512'(o_rlast), 512'(0));
    check("rst_resp", 512'({o_rresp, o_bresp}), 512'(0));
    check("rst_line", o_cache_line, 512'(0));
    check("rst_valid", 512'(o_line_valid), 512'(0));
    check("rst_busy", 512'(o_busy), 512'(0));
    ace_areset = 1'b0;
    #1 check("idle_arready", 512'(o_arready), 512'(1));

    // Preload hit, then miss, then short-burst error read.
    pl = {128'hA3A3, 128'hA2A2, 128'hA1A1, 128'hA0A0};
    preload(44'h1000, pl, 1'b1);
    read_txn(44'h1000, 8'd3, 1'b0, 1'b0);
    read_txn(44'h2000, 8'd3, 1'b0, 1'b1);
    read_txn(44'h2000, 8'd1, 1'b0, 1'b0);

    // Write with gaps, read it back, then the two error writes.
    write_txn(44'h3000, 8'd3, 4, 1'b1, 1'b0);
    read_txn(44'h3000, 8'd3, 1'b1, 1'b0);
    write_txn(44'h3000, 8'd3, 2, 1'b0, 1'b1);
    write_txn(44'h3000, 8'd0, 1, 1'b0, 1'b0);

    // Simultaneous AR/AW: read first, AW taken the cycle rack returns to IDLE.
    i_awvalid = 1'b1; i_awaddr = 44'h4000; i_awlen = 8'd3;
    i_arvalid = 1'b1; i_araddr = 44'h1000; i_arlen = 8'd3;
    #1 check("sim_awready", 512'(o_awready), 512'(0));
    check("sim_arready", 512'(o_arready), 512'(1));
    read_txn(44'h1000, 8'd3, 1'b0, 1'b0);
    write_txn(44'h4000, 8'd3, 4, 1'b0, 1'b0);

    // Reset while beat 2 of a read is on the bus.
    pl = {rand128(), rand128(), rand128(), rand128()};
    preload(44'h5000, pl, 1'b0);
    i_arvalid = 1'b1; i_araddr = 44'h5000; i_arlen = 8'd3;
    cycle();
    i_arvalid = 1'b0; i_rready = 1'b1;
    repeat (2) cycle();
    #1 check("rst_mid_rdata", 512'(o_rdata), 512'(m_line[2]));
    ace_areset = 1'b1;
    cycle();
    ace_areset = 1'b0; i_rready = 1'b0;
    for (int i = 0; i < 4; i++) m_line[i] = '0;
    m_tag = '0; m_valid = 1'b0;
    #1 check("rst_mid_rvalid", 512'(o_rvalid), 512'(0));
    check("rst_mid_state", 512'(o_fsm_state), 512'(ST_IDLE));
    check("rst_mid_valid", 512'(o_line_valid), 512'(0));
    check("rst_mid_line", o_cache_line, model_line());

    // Randomized mix over a few tags, offsets and lengths.
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      a = bases[$urandom_range(0, 2)] | 44'($urandom_range(0, 63));
      ln8 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 5)) : 8'd3;
      case (kind)
        0: begin
          pl = {rand128(), rand128(), rand128(), rand128()};
          preload(a, pl, 1'($urandom_range(0, 1)));
        end
        3: begin
          if (ln8 == 8'd3) nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 4;
          else             nb = $urandom_range(1, 5);
          write_txn(a, ln8, nb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        default: read_txn(a, ln8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
